// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - Pong match sequencer: serve/play/point/over flow, scoring and ball gating
// All outputs come from flops; the registered outputs are decoded from next-state values.
module pong_match_ctrl #(
  parameter int WIN_SCORE          = 7,
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int POINT_DELAY_FRAMES = 90,
  parameter int SCORE_W            = 4,
  parameter int CNT_W              = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               frame_tick,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               paddle_en,
  output logic               ball_reset,
  output logic               ball_launch,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] player_score,
  output logic [SCORE_W-1:0] ai_score,
  output logic               game_over,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] ONE_PT   = SCORE_W'(1);
  localparam logic [CNT_W-1:0]   SERVE_CT = CNT_W'(SERVE_DELAY_FRAMES);
  localparam logic [CNT_W-1:0]   POINT_CT = CNT_W'(POINT_DELAY_FRAMES);
  localparam logic [CNT_W-1:0]   ONE_CT   = CNT_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] player_d, ai_d;
  logic               dir_d, launch_d;
  logic               start_q;
  logic               start_edge;

  assign start_edge = start & ~start_q;
  assign state      = state_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    player_d = player_score;
    ai_d     = ai_score;
    dir_d    = serve_dir;
    launch_d = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_edge) begin
          state_d  = S_SERVE;
          cnt_d    = SERVE_CT;
          player_d = '0;
          ai_d     = '0;
          dir_d    = 1'b0;
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          cnt_d = cnt_q - ONE_CT;
          if (cnt_q == ONE_CT) begin
            state_d  = S_PLAY;
            launch_d = 1'b1;
          end
        end
      end
      S_PLAY: begin
        // A simultaneous double miss is a replay: nobody scores
        if (miss_left && miss_right) begin
          state_d = S_POINT;
          cnt_d   = POINT_CT;
        end else if (miss_left) begin
          if (ai_score != WIN) ai_d = ai_score + ONE_PT;
          dir_d   = 1'b0;
          cnt_d   = POINT_CT;
          state_d = (ai_d == WIN) ? S_OVER : S_POINT;
        end else if (miss_right) begin
          if (player_score != WIN) player_d = player_score + ONE_PT;
          dir_d   = 1'b1;
          cnt_d   = POINT_CT;
          state_d = (player_d == WIN) ? S_OVER : S_POINT;
        end
      end
      S_POINT: begin
        if (frame_tick) begin
          if (cnt_q == ONE_CT) begin
            state_d = S_SERVE;
            cnt_d   = SERVE_CT;
          end else begin
            cnt_d = cnt_q - ONE_CT;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        player_d = '0;
        ai_d     = '0;
        dir_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      player_score <= '0;
      ai_score     <= '0;
      start_q      <= 1'b0;
      serve_dir    <= 1'b0;
      ball_launch  <= 1'b0;
      paddle_en    <= 1'b0;
      ball_reset   <= 1'b1;
      game_over    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      player_score <= player_d;
      ai_score     <= ai_d;
      start_q      <= start;
      serve_dir    <= dir_d;
      ball_launch  <= launch_d;
      paddle_en    <= (state_d == S_SERVE) || (state_d == S_PLAY);
      ball_reset   <= (state_d != S_PLAY);
      game_over    <= (state_d == S_OVER);
    end
  end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
Top-level match sequencer for the Pong game.
- Gates the player and AI paddle motion.
- Holds, releases and launches the ball; sets the serve direction.
- Keeps both scores and detects the end of the match.
- Sits between the input conditioning (start button, frame tick) and the paddle/ball datapath; consumes the ball logic's edge-miss pulses.

Parameters:
WIN_SCORE, 7, points needed to win; legal range 1..(2^SCORE_W)-1
SERVE_DELAY_FRAMES, 60, frames the ball is held centred before launch; must be >=1
POINT_DELAY_FRAMES, 90, frames of pause after a point; must be >=1
SCORE_W, 4, score counter width
CNT_W, 8, frame delay counter width; must hold max(SERVE_DELAY_FRAMES, POINT_DELAY_FRAMES)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  start button, level, already debounced; block detects the rising edge internally
frame_tick  input  1  one-cycle pulse per video frame
miss_left  input  1  one-cycle pulse: ball passed the player (left) paddle
miss_right  input  1  one-cycle pulse: ball passed the AI (right) paddle
paddle_en  output  1  1 = paddles may move
ball_reset  output  1  1 = ball forced to centre, velocity zero
ball_launch  output  1  one-cycle pulse: ball starts moving
serve_dir  output  1  0 = serve toward left/player, 1 = toward right/AI
player_score  output  SCORE_W  player points
ai_score  output  SCORE_W  AI points
game_over  output  1  match finished
state  output  3  debug: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4

Behaviour:
- All outputs are registered; state, counter, scores and start_q update only on the rising edge of clk.
- Start edge: start_edge = start & ~start_q.
- Reset (any state, mid-match included): values below appear at the next edge. Pulses arriving in the reset cycle are ignored.
  - state=IDLE, player_score=ai_score=0, cnt=0, start_q=0
  - paddle_en=0, ball_reset=1, ball_launch=0, serve_dir=0, game_over=0
- IDLE: paddle_en=0, ball_reset=1.
  - start_edge -> SERVE; clear scores; cnt=SERVE_DELAY_FRAMES; serve_dir=0.
- SERVE: paddle_en=1, ball_reset=1.
  - Each frame_tick decrements cnt.
  - frame_tick while cnt==1 -> PLAY; ball_launch=1 in the first PLAY cycle only.
- PLAY: paddle_en=1, ball_reset=0.
  - miss_left only: ai_score+1; serve_dir=0 (serve toward the point loser).
  - miss_right only: player_score+1; serve_dir=1.
  - Both in the same cycle: no score change, serve_dir unchanged; treated as a replay -> POINT.
  - After a score: new score==WIN_SCORE -> OVER; otherwise -> POINT with cnt=POINT_DELAY_FRAMES.
  - Latency: miss pulse sampled at edge N -> updated score and new state visible after edge N.
- POINT: paddle_en=0, ball_reset=1.
  - frame_tick decrements cnt.
  - frame_tick while cnt==1 -> SERVE with cnt=SERVE_DELAY_FRAMES.
- OVER: game_over=1, paddle_en=0, ball_reset=1; scores frozen.
  - start_edge -> SERVE; clear scores; serve_dir=0; game_over=0.
- Ignored inputs:
  - miss_left/miss_right outside PLAY.
  - start_edge outside IDLE/OVER; holding start high never retriggers.
  - frame_tick in IDLE, PLAY, OVER.
- Scores saturate at WIN_SCORE and never wrap.
- Undefined state encodings (5..7) -> IDLE at the next edge, outputs at their reset values.

Test Plan:
(Bench parameters: WIN_SCORE=3, SERVE_DELAY_FRAMES=2, POINT_DELAY_FRAMES=2.)
1. Reset then start rising -> SERVE next cycle, paddle_en=1, ball_reset=1. After 2 frame_ticks -> PLAY, exactly one ball_launch pulse, ball_reset=0.
2. In PLAY, miss_right pulse -> next cycle player_score=1, serve_dir=1, state=POINT, paddle_en=0. After 2 ticks -> SERVE; after 2 more -> PLAY.
3. Three miss_left across three rallies -> ai_score=3, state=OVER, game_over=1. Further miss pulses and ticks leave all outputs unchanged.
4. miss_left and miss_right in the same PLAY cycle -> scores unchanged, state=POINT, serve_dir unchanged. Miss pulses injected during SERVE/POINT -> ignored.
5. start held high from IDLE through OVER -> only one transition to SERVE. In OVER, release then reassert start -> SERVE, scores=0, game_over=0.
6. Assert reset mid-PLAY with player_score=2 -> next cycle IDLE, scores 0, ball_reset=1, paddle_en=0, ball_launch=0.
